// File: rtl/cpu_loader_pkg.sv
// Shared loader/dumper definitions: stream marker words and FSM encodings.
// Checksum phase is only reached when CPU_DUMP_CHECKSUM_EN is defined.
package cpu_loader_pkg;

    localparam logic [23:0] START_WORD   = 24'hFF0000;
    localparam logic [23:0] END_KEEP_PC  = 24'hFFF000;
    localparam logic [23:0] END_RESET_PC = 24'hFFFF00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_READ,
        ST_SEND,
        ST_END,
        ST_DONE
    } dump_state_e;

    typedef enum logic [1:0] {
        PH_START_W,
        PH_DATA_W,
        PH_CSUM_W,
        PH_END_W
    } dump_phase_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_WAIT
    } hs_state_e;

    // Byte idx of a 24-bit word, LSB byte first; idx 3 never occurs.
    function automatic logic [7:0] word_byte(input logic [23:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            default: b = w[23:16];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cpu_instruction_dumper_if.sv
// UART tx handshake and iRAM read port of the instruction dumper.
interface cpu_instruction_dumper_if #(parameter int ADDR_W = 8);

    // Four-phase tx: source raises tx_req with tx_byte stable, sink raises tx_ack,
    // source drops tx_req, sink drops tx_ack; tx_req never rises while tx_ack is high.
    logic              tx_req;
    logic [7:0]        tx_byte;
    logic              tx_ack;
    logic              iRAM_read_enable;
    logic [ADDR_W-1:0] extern_iRAM_addr;
    logic              iRAM_data_valid;
    logic [23:0]       iRAM_data_out;

    modport master (
        output tx_req, tx_byte, iRAM_read_enable, extern_iRAM_addr,
        input  tx_ack, iRAM_data_valid, iRAM_data_out
    );

    modport slave (
        input  tx_req, tx_byte, iRAM_read_enable, extern_iRAM_addr,
        output tx_ack, iRAM_data_valid, iRAM_data_out
    );

endinterface

// File: rtl/cpu_instruction_dumper_tx.sv
// Four-phase req/ack byte driver; latches the byte on start and pulses done
// once the sink has released tx_ack.
module tx_byte_handshake
    import cpu_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       tx_ack_i,
    output logic       tx_req_o,
    output logic [7:0] tx_byte_o,
    output logic       done_o,
    output hs_state_e  state_o
);

    hs_state_e  state_q, state_d;
    logic [7:0] byte_q, byte_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_IDLE;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        done_o  = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (start_i) begin
                    byte_d  = byte_i;
                    state_d = HS_REQ;
                end
            end
            HS_REQ: begin
                if (tx_ack_i) state_d = HS_WAIT;
            end
            HS_WAIT: begin
                if (!tx_ack_i) begin
                    done_o  = 1'b1;
                    state_d = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    assign tx_req_o  = (state_q == HS_REQ);
    assign tx_byte_o = byte_q;
    assign state_o   = state_q;

endmodule

// File: rtl/cpu_instruction_dumper.sv
// Dumps iRAM words 0..DEPTH-1 to the UART framed by start/end marker words.
// Define CPU_DUMP_CHECKSUM_EN to append an 8-bit data checksum word before the end word.
module cpu_instruction_dumper
    import cpu_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dump_req,
    input  logic                     HALT_flag,
    cpu_instruction_dumper_if.master bus,
    output logic                     cpu_paused,
    output logic                     dump_busy,
    output logic                     dump_done,
    output dump_state_e              dbg_state_o,
    output hs_state_e                dbg_hs_state_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    dump_state_e       state_q, state_d;
    dump_phase_e       phase_q, phase_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_buf_q, word_buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              paused_q, paused_d;
    logic              inflight_q, inflight_d;
    logic              hs_start, hs_done;
`ifdef CPU_DUMP_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_START_W;
            byte_idx_q <= 2'd0;
            word_buf_q <= 24'h000000;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            paused_q   <= 1'b0;
            inflight_q <= 1'b0;
`ifdef CPU_DUMP_CHECKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            paused_q   <= paused_d;
            inflight_q <= inflight_d;
`ifdef CPU_DUMP_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        addr_d     = addr_q;
        rd_en_d    = rd_en_q;
        paused_d   = paused_q;
        inflight_d = inflight_q;
        hs_start   = 1'b0;
`ifdef CPU_DUMP_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dump_req && HALT_flag) begin
                    paused_d   = 1'b1;
                    word_buf_d = START_WORD;
                    phase_d    = PH_START_W;
                    byte_idx_d = 2'd0;
                    addr_d     = '0;
`ifdef CPU_DUMP_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!inflight_q) begin
                    hs_start   = 1'b1;
                    inflight_d = 1'b1;
`ifdef CPU_DUMP_CHECKSUM_EN
                    if (phase_q == PH_DATA_W) sum_d = sum_q + word_byte(word_buf_q, byte_idx_q);
`endif
                end else if (hs_done) begin
                    inflight_d = 1'b0;
                    if (byte_idx_q == 2'd2) begin
                        byte_idx_d = 2'd0;
                        case (phase_q)
                            PH_START_W: state_d = ST_READ;
                            PH_DATA_W: begin
                                if (addr_q == LAST_ADDR) begin
`ifdef CPU_DUMP_CHECKSUM_EN
                                    word_buf_d = {16'h0000, sum_q};
                                    phase_d    = PH_CSUM_W;
`else
                                    word_buf_d = END_KEEP_PC;
                                    phase_d    = PH_END_W;
`endif
                                end else begin
                                    addr_d  = addr_q + ADDR_W'(1);
                                    state_d = ST_READ;
                                end
                            end
                            PH_CSUM_W: begin
                                word_buf_d = END_KEEP_PC;
                                phase_d    = PH_END_W;
                            end
                            default: state_d = ST_DONE;
                        endcase
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            ST_READ: begin
                // Strobe stays up until the RAM answers; latency is unbounded.
                rd_en_d = 1'b1;
                if (rd_en_q && bus.iRAM_data_valid) begin
                    word_buf_d = bus.iRAM_data_out;
                    rd_en_d    = 1'b0;
                    phase_d    = PH_DATA_W;
                    state_d    = ST_SEND;
                end
            end
            ST_DONE: begin
                paused_d = 1'b0;
                addr_d   = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    tx_byte_handshake u_tx (
        .clk       (clk),
        .rst       (rst),
        .start_i   (hs_start),
        .byte_i    (word_byte(word_buf_q, byte_idx_q)),
        .tx_ack_i  (bus.tx_ack),
        .tx_req_o  (bus.tx_req),
        .tx_byte_o (bus.tx_byte),
        .done_o    (hs_done),
        .state_o   (dbg_hs_state_o)
    );

    assign bus.iRAM_read_enable = rd_en_q;
    assign bus.extern_iRAM_addr = addr_q;
    assign cpu_paused           = paused_q;
    assign dump_busy            = (state_q != ST_IDLE);
    assign dump_done            = (state_q == ST_DONE);
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_cpu_instruction_dumper.sv
// Bench for cpu_instruction_dumper (DEPTH=4): random ack/read latencies against a byte-stream model.
`timescale 1ns/1ps
module tb_cpu_instruction_dumper;
    import cpu_loader_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dump_req = 1'b0;
    logic        HALT_flag = 1'b0;
    logic        cpu_paused, dump_busy, dump_done;
    dump_state_e dbg_state;
    hs_state_e   dbg_hs_state;

    cpu_instruction_dumper_if #(.ADDR_W(ADDR_W)) bus ();

    cpu_instruction_dumper #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .dump_req       (dump_req),
        .HALT_flag      (HALT_flag),
        .bus            (bus),
        .cpu_paused     (cpu_paused),
        .dump_busy      (dump_busy),
        .dump_done      (dump_done),
        .dbg_state_o    (dbg_state),
        .dbg_hs_state_o (dbg_hs_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [23:0] mem[DEPTH];
    int          ack_dly_min = 0, ack_dly_max = 0, ack_hold = 1;
    int          rd_dly = 1;
    bit          rd_rand = 0, rd_check = 0;
    int          ack_count = 0, done_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_word(input logic [23:0] w);
        for (int b = 0; b < 3; b++) exp_q.push_back(8'((w >> (8 * b)) & 24'hFF));
    endtask

    task automatic model_dump();
`ifdef CPU_DUMP_CHECKSUM_EN
        int sum = 0;
`endif
        push_word(24'hFF0000);
        for (int i = 0; i < DEPTH; i++) begin
            push_word(mem[i]);
`ifdef CPU_DUMP_CHECKSUM_EN
            sum += int'(mem[i][7:0]) + int'(mem[i][15:8]) + int'(mem[i][23:16]);
`endif
        end
`ifdef CPU_DUMP_CHECKSUM_EN
        push_word(24'(sum % 256));
`endif
        push_word(24'hFFF000);
    endtask

    // ---------------- UART sink ----------------
    initial begin : ack_responder
        bus.tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_req && !bus.tx_ack) begin
                repeat ($urandom_range(ack_dly_max, ack_dly_min)) @(negedge clk);
                bus.tx_ack = 1'b1;
                for (int n = 0; n < 500 && bus.tx_req; n++) @(negedge clk);
                repeat (ack_hold - 1) @(negedge clk);
                bus.tx_ack = 1'b0;
            end
        end
    end

    // ---------------- iRAM model ----------------
    initial begin : iram_responder
        logic [ADDR_W-1:0] a;
        int d;
        bus.iRAM_data_valid = 1'b0;
        bus.iRAM_data_out   = 24'h0;
        forever begin
            @(negedge clk);
            if (bus.iRAM_read_enable && !rst) begin
                a = bus.extern_iRAM_addr;
                d = rd_rand ? int'($urandom_range(6, 1)) : rd_dly;
                check("addr_in_range", 32'(a < DEPTH), 1);
                for (int k = 1; k < d; k++) begin
                    @(negedge clk);
                    if (!rst) check("addr_stable", 32'(bus.extern_iRAM_addr), 32'(a));
                end
                bus.iRAM_data_valid = 1'b1;
                bus.iRAM_data_out   = mem[a[1:0]];
                @(negedge clk);
                bus.iRAM_data_valid = 1'b0;
                bus.iRAM_data_out   = 24'($urandom);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic       prev_req, prev_ack, prev_rd;
        logic [7:0] held;
        int         rd_cnt;
        prev_req = 0; prev_ack = 0; prev_rd = 0; held = 0; rd_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_req = 0; prev_ack = 0; prev_rd = 0; rd_cnt = 0;
            end else begin
                if (bus.tx_req && !prev_req) begin
                    check("req_rise_ack_low", 32'(bus.tx_ack), 0);
                    check("paused_during_byte", 32'(cpu_paused), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got %0h expected none at %0t", bus.tx_byte, $time);
                    end else begin
                        check("tx_byte", 32'(bus.tx_byte), 32'(exp_q.pop_front()));
                    end
                    held = bus.tx_byte;
                end else if (bus.tx_req) begin
                    check("tx_byte_stable", 32'(bus.tx_byte), 32'(held));
                end
                if (bus.tx_ack && !prev_ack) ack_count++;
                if (dump_done) done_count++;
                if (bus.iRAM_read_enable) rd_cnt++;
                else if (prev_rd) begin
                    if (rd_check) check("rd_en_hold", 32'(rd_cnt), 32'(rd_dly));
                    rd_cnt = 0;
                end
                prev_req = bus.tx_req;
                prev_ack = bus.tx_ack;
                prev_rd  = bus.iRAM_read_enable;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_tx_req"}, 32'(bus.tx_req), 0);
        check({tag, "_tx_byte"}, 32'(bus.tx_byte), 0);
        check({tag, "_cpu_paused"}, 32'(cpu_paused), 0);
        check({tag, "_rd_en"}, 32'(bus.iRAM_read_enable), 0);
        check({tag, "_addr"}, 32'(bus.extern_iRAM_addr), 0);
        check({tag, "_busy"}, 32'(dump_busy), 0);
        check({tag, "_done"}, 32'(dump_done), 0);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
    endtask

    task automatic run_dump(input string tag);
        int base, n;
        base = done_count;
        exp_q.delete();
        model_dump();
        HALT_flag = 1'b1;
        pulse_req();
        n = 0;
        while (done_count == base && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_count - base), 1);
        check({tag, "_bytes_left"}, 32'(exp_q.size()), 0);
        check({tag, "_paused_after"}, 32'(cpu_paused), 0);
        check({tag, "_busy_after"}, 32'(dump_busy), 0);
        exp_q.delete();
    endtask

    task automatic load_fixed();
        mem[0] = 24'h000001;
        mem[1] = 24'hABCDEF;
        mem[2] = 24'h123456;
        mem[3] = 24'hFFFFFF;
    endtask

    task automatic load_random(input bit with_markers);
        for (int i = 0; i < DEPTH; i++) begin
            if (with_markers && $urandom_range(2, 0) == 0) mem[i] = (i % 2 == 1) ? 24'hFF0000 : 24'hFFF000;
            else mem[i] = 24'($urandom);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : stimulus
        int n, busy_seen, req_seen, paused_seen, base;

        load_fixed();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fixed vector, immediate ack, single-cycle read.
        ack_dly_min = 0; ack_dly_max = 0; ack_hold = 1;
        rd_dly = 1; rd_rand = 0; rd_check = 1;
        run_dump("fixed");

        // Request without HALT is ignored.
        HALT_flag = 1'b0;
        busy_seen = 0; req_seen = 0; paused_seen = 0;
        pulse_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_seen   += int'(dump_busy);
            req_seen    += int'(bus.tx_req);
            paused_seen += int'(cpu_paused);
        end
        check("nohalt_busy", 32'(busy_seen), 0);
        check("nohalt_tx_req", 32'(req_seen), 0);
        check("nohalt_paused", 32'(paused_seen), 0);

        // Slow RAM: read strobe held for the full latency.
        rd_dly = 7;
        run_dump("slow_read");

        // Slow, sticky ack; HALT drops and a second request arrives mid-dump.
        ack_dly_min = 5; ack_dly_max = 20; ack_hold = 3;
        rd_rand = 1; rd_check = 0;
        load_random(0);
        fork
            run_dump("slow_ack");
            begin
                repeat (60) @(negedge clk);
                HALT_flag = 1'b0;
                dump_req  = 1'b1;
                @(negedge clk);
                dump_req  = 1'b0;
            end
        join

        // Reset after the fifth acked byte, then a clean restart.
        ack_dly_min = 0; ack_dly_max = 0; ack_hold = 1;
        rd_rand = 0; rd_dly = 1; rd_check = 1;
        load_fixed();
        exp_q.delete();
        model_dump();
        base = ack_count;
        HALT_flag = 1'b1;
        pulse_req();
        n = 0;
        while (ack_count < base + 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("acks_before_rst", 32'(ack_count - base), 5);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        run_dump("restart");

        // Random data including marker look-alikes, random latencies.
        for (int t = 0; t < 3; t++) begin
            ack_dly_min = 0; ack_dly_max = 4; ack_hold = int'($urandom_range(3, 1));
            rd_rand = 1; rd_check = 0;
            load_random(1);
            run_dump("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_instruction_dumper.md
Name: cpu_instruction_dumper

Overview:
Readback path for instruction RAM. On a host request, the block pauses the CPU and reads iRAM words 0..DEPTH-1. Each 24-bit word is serialised LSB byte first to the UART transmitter over a four-phase req/ack handshake. The stream is framed with the same start (FF0000) and end (FFF000) words the loader accepts, so a dump can be replayed verbatim into the loader.

Parameters:
DEPTH, 256, number of iRAM words dumped (1..256); addresses 0..DEPTH-1.
ADDR_W, 8, iRAM address width.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
dump_req  in  1  level/pulse; sampled in IDLE only.
HALT_flag  in  1  CPU halted; dump starts only when high.
tx_ack  in  1  UART tx accepted tx_byte (four-phase).
iRAM_data_valid  in  1  iRAM read data valid for extern_iRAM_addr.
iRAM_data_out  in  24  iRAM read data.
tx_req  out  1  byte available on tx_byte.
tx_byte  out  8  byte to transmit.
cpu_paused  out  1  high from dump start until DONE completes.
iRAM_read_enable  out  1  read strobe, held until iRAM_data_valid.
extern_iRAM_addr  out  ADDR_W  current read address.
dump_busy  out  1  high in any state except IDLE.
dump_done  out  1  one-cycle pulse when the end word's last byte is acked.

Behaviour:
- Reset: all outputs 0; state IDLE; byte_idx 0; word buffer 0. Reset mid-dump aborts immediately. tx_req drops and cpu_paused releases. No end word is sent.
- States: IDLE, START, READ, SEND, END, DONE. Phase register {START_W, DATA_W, END_W} selects the word source.
- IDLE: if dump_req && HALT_flag, then cpu_paused<=1, word_buf<=24'hFF0000, phase START_W, go to SEND. dump_req without HALT_flag is ignored.
- SEND, per byte:
  - tx_byte = word_buf[8*byte_idx +: 8].
  - Assert tx_req. Wait for tx_ack=1, then drop tx_req.
  - Wait for tx_ack=0, then advance byte_idx.
  - tx_byte is stable while tx_req is high. A new tx_req is never raised while tx_ack is still high.
  - After byte_idx 2 completes, byte_idx<=0 and the next state depends on phase:
    - START_W: go to READ.
    - DATA_W: if addr==DEPTH-1, word_buf<=24'hFFF000, phase END_W. Otherwise addr+1, then READ.
    - END_W: go to DONE.
- READ: iRAM_read_enable<=1. When iRAM_data_valid: word_buf<=iRAM_data_out, iRAM_read_enable<=0, phase DATA_W, go to SEND. Read latency is unbounded.
- DONE: cpu_paused<=0, dump_done<=1 for one cycle, extern_iRAM_addr<=0, go to IDLE.
- Byte count per dump: 3*(DEPTH+2), or plus 3 with the optional feature.
- HALT_flag falling mid-dump is ignored. dump_req while busy is ignored.
- Data words equal to FF0000/FFF000 are sent unescaped; this matches the loader.
- Address never wraps. DEPTH=1 sends start, word 0, end.
- Minimum per byte: 4 cycles plus ack latency.

Optional Feature:
CPU_DUMP_CHECKSUM_EN:
- Defined: a running 8-bit sum (mod 256) accumulates every data byte sent. After the last data word, the word {16'h0000, sum} is sent before the end word. The sum clears at dump start.
- Undefined: no checksum logic; the stream is start, data, end only.

Decomposition:
- Shared package (cpu_loader_pkg): marker constants START_WORD=24'hFF0000, END_KEEP_PC=24'hFFF000, END_RESET_PC=24'hFFFF00; phase/state encodings. Loader and dumper both import it.
- Sub-module tx_byte_handshake: four-phase req/ack driver.
  - Inputs: start, byte.
  - Outputs: tx_req, tx_byte, done.
  - The dumper sequences bytes through it.

Test Plan:
- DEPTH=4, iRAM={000001,ABCDEF,123456,FFFFFF}, HALT_flag=1, dump_req pulse -> tx bytes 00 00 FF 01 00 00 EF CD AB 56 34 12 FF FF FF 00 F0 FF; dump_done pulses once; cpu_paused high throughout, then 0.
- dump_req with HALT_flag=0 -> no tx_req, cpu_paused stays 0, dump_busy 0.
- tx_ack delayed 5-20 random cycles and held high 3 cycles -> tx_req never reasserts while tx_ack is high; tx_byte stable while tx_req is high; byte order unchanged.
- iRAM_data_valid delayed 7 cycles -> iRAM_read_enable held 7 cycles; extern_iRAM_addr stable; correct word sent.
- rst asserted after the 5th byte ack -> next cycle all outputs 0; a new dump_req restarts from start word and address 0.
- CPU_DUMP_CHECKSUM_EN, DEPTH=2, words {010203,040506} -> checksum word 000015 (bytes 15 00 00) sent before the end word.
